riscv_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_shifter.sv | 39 +++
 rtl/riscv_alu.sv | 99 +++++++++
 tb/tb_riscv_alu.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the RV32I execute-stage ALU.
// Contents:
//   XLEN     - datapath width (32).
//   SHAMT_W  - width of the shift amount (5).
//   ALU_*    - 4-bit operation codes, encoded as {funct7[5], funct3}.
//   shift_kind_e - direction and fill mode selector for alu_shifter.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  // Operation codes. The MSB is funct7[5], so that SUB and SRA sit directly
  // above ADD and SRL and decoding straight from the instruction is trivial.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Shifter mode. Left shifts reuse the right-shift network on a
  // bit-reversed operand, so only the fill bit differs between the two
  // right-shift modes.
  typedef enum logic [1:0] {
    SHIFT_LL = 2'b00,
    SHIFT_RL = 2'b01,
    SHIFT_RA = 2'b10
  } shift_kind_e;

  // Reverse the bit order of a datapath word.
  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] value);
    logic [XLEN-1:0] reversed;
    reversed = '0;
    for (int i = 0; i < XLEN; i++) begin
      reversed[i] = value[XLEN-1-i];
    end
    return reversed;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter
// Combinational 5-stage barrel shifter covering SLL, SRL and SRA.
// Ports:
//   data_in  [XLEN-1:0]    value to shift (operand A)
//   shamt    [SHAMT_W-1:0] shift amount, 0..31
//   kind     shift_kind_e  left logical / right logical / right arithmetic
//   data_out [XLEN-1:0]    shifted value
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_kind_e        kind,
  output logic [XLEN-1:0]    data_out
);

  logic [SHAMT_W:0][XLEN-1:0] stage;
  logic                       fill;

  // Left shifts are done as right shifts of the bit-reversed word, then
  // reversed back on the way out; this keeps one shifting network. Only an
  // arithmetic right shift fills with the sign bit.
  always_comb begin
    stage[0] = (kind == SHIFT_LL) ? bit_reverse(data_in) : data_in;
    fill     = (kind == SHIFT_RA) & data_in[XLEN-1];
  end

  // Stage i shifts right by 2**i when shamt[i] is set.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int STEP = 1 << i;
    assign stage[i+1] = shamt[i] ? {{STEP{fill}}, stage[i][XLEN-1:STEP]}
                                 : stage[i];
  end

  always_comb begin
    data_out = (kind == SHIFT_LL) ? bit_reverse(stage[SHAMT_W]) : stage[SHAMT_W];
  end

endmodule

// File: rtl/riscv_alu.sv
// riscv_alu
// Combinational 32-bit integer ALU for the RV32I execute stage.
// Ports:
//   clk    in   1     pipeline clock, present for interface uniformity only
//   reset  in   1     async active-high reset, present for uniformity only
//   a      in   32    operand A (rs1 / PC)
//   b      in   32    operand B (rs2 / immediate); shifts use b[4:0]
//   op     in   4     operation select {funct7[5], funct3}
//   result out  32    operation result (0 for undefined op codes)
//   zero   out  1     result == 0
//   equal  out  1     a == b, independent of op
module riscv_alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            equal
);

  logic            sub_en;
  logic [XLEN-1:0] b_operand;
  logic [XLEN:0]   sum;
  logic            slt_bit;
  logic            sltu_bit;
  shift_kind_e     shift_kind;
  logic [XLEN-1:0] shift_out;

  // The block holds no state, so clock and reset are only tied off here.
  logic unused_ports;
  assign unused_ports = &{1'b0, clk, reset};

  // One shared adder serves ADD, SUB, SLT and SLTU. Subtraction is a + ~b + 1
  // on a 33-bit path, so bit 32 is the carry out and its inverse is the
  // borrow of a - b.
  always_comb begin
    sub_en = 1'b0;
    case (op)
      ALU_SUB, ALU_SLT, ALU_SLTU: sub_en = 1'b1;
      default:                    sub_en = 1'b0;
    endcase
    b_operand = sub_en ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_operand} + {{XLEN{1'b0}}, sub_en};
  end

  // Signed compare: with differing signs the negative operand is smaller;
  // with equal signs the difference cannot overflow, so its sign bit is
  // the answer. Unsigned compare is simply the borrow.
  always_comb begin
    slt_bit  = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : sum[XLEN-1];
    sltu_bit = ~sum[XLEN];
  end

  // Select the shifter mode; every non-shift op parks it in logical right.
  always_comb begin
    shift_kind = SHIFT_RL;
    case (op)
      ALU_SLL: shift_kind = SHIFT_LL;
      ALU_SRA: shift_kind = SHIFT_RA;
      default: shift_kind = SHIFT_RL;
    endcase
  end

  alu_shifter u_shifter (
    .data_in  (a),
    .shamt    (b[SHAMT_W-1:0]),
    .kind     (shift_kind),
    .data_out (shift_out)
  );

  // Final result mux; undefined codes drive zero so outputs never go X.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD,
      ALU_SUB:  result = sum[XLEN-1:0];
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, slt_bit};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, sltu_bit};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  result = shift_out;
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  // Flags: zero follows the selected result, equal is a plain operand compare.
  always_comb begin
    zero  = (result == '0);
    equal = (a == b);
  end

endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu
// Self-checking bench for riscv_alu: a table of directed vectors, a reset
// toggling sequence and a random regression against a reference model.
// Expected values go into a scoreboard queue when stimulus is applied and
// are popped and compared once the outputs have settled.
module tb_riscv_alu;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] result;
  logic        zero;
  logic        equal;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        zero;
    logic        equal;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        equal;
  } vec_t;

  exp_t scoreboard[$];
  vec_t vecs[17];
  int   checkCount;
  int   errorCount;

  riscv_alu dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .op     (op),
    .result (result),
    .zero   (zero),
    .equal  (equal)
  );

  // Free-running clock; stimulus changes on the falling edge and outputs are
  // sampled just after the rising edge, well away from any input change.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference model built from plain language operators.
  function automatic logic [31:0] modelResult(input logic [3:0] mop,
                                              input logic [31:0] ma,
                                              input logic [31:0] mb);
    case (mop)
      4'b0000: return ma + mb;
      4'b1000: return ma - mb;
      4'b0001: return ma << mb[4:0];
      4'b0010: return ($signed(ma) < $signed(mb)) ? 32'h1 : 32'h0;
      4'b0011: return (ma < mb) ? 32'h1 : 32'h0;
      4'b0100: return ma ^ mb;
      4'b0101: return ma >> mb[4:0];
      4'b1101: return $unsigned($signed(ma) >>> mb[4:0]);
      4'b0110: return ma | mb;
      4'b0111: return ma & mb;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one operation on the falling edge and record what it should give.
  task automatic applyStimulus(input string name, input logic [3:0] sop,
                               input logic [31:0] sa, input logic [31:0] sb,
                               input logic [31:0] eres, input logic ezero,
                               input logic eequal);
    exp_t e;
    @(negedge clk);
    op = sop;
    a  = sa;
    b  = sb;
    e.name   = name;
    e.result = eres;
    e.zero   = ezero;
    e.equal  = eequal;
    scoreboard.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the settled outputs.
  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    checkCount++;
    if (scoreboard.size() == 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_empty got 0 entries required 1");
      return;
    end
    e = scoreboard.pop_front();
    if (result !== e.result) begin
      errorCount++;
      $display("[TB] FAIL %s.result got %h required %h", e.name, result, e.result);
    end
    checkCount++;
    if (zero !== e.zero) begin
      errorCount++;
      $display("[TB] FAIL %s.zero got %b required %b", e.name, zero, e.zero);
    end
    checkCount++;
    if (equal !== e.equal) begin
      errorCount++;
      $display("[TB] FAIL %s.equal got %b required %b", e.name, equal, e.equal);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    a     = '0;
    b     = '0;
    op    = '0;

    vecs[0]  = '{"add_wrap",   4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{"sub_equal",  4'b1000, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1};
    vecs[2]  = '{"sub_under",  4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{"slt_neg",    4'b0010, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[4]  = '{"sltu_big",   4'b0011, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{"sra_4",      4'b1101, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0};
    vecs[6]  = '{"srl_4",      4'b0101, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0};
    vecs[7]  = '{"sll_31",     4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0};
    vecs[8]  = '{"and",        4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    vecs[9]  = '{"or",         4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
    vecs[10] = '{"xor",        4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
    vecs[11] = '{"undef_f",    4'b1111, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
    vecs[12] = '{"slt_pos_gt", 4'b0010, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{"sra_zero",   4'b1101, 32'h7FFFFFFF, 32'hFFFFFFE0, 32'h7FFFFFFF, 1'b0, 1'b0};
    vecs[14] = '{"slt_bothneg",4'b0010, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
    vecs[15] = '{"sltu_gt",    4'b0011, 32'h00000007, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[16] = '{"undef_a",    4'b1010, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0};

    // Outputs must already follow inputs while reset is held.
    applyStimulus("in_reset", 4'b0000, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0);
    checkOutput();
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].result, vecs[i].zero, vecs[i].equal);
      checkOutput();
    end

    // Toggle reset around a held operation; nothing may change.
    applyStimulus("rst_before", 4'b1000, 32'h00000010, 32'h00000003, 32'h0000000D, 1'b0, 1'b0);
    checkOutput();
    reset = 1'b1;
    applyStimulus("rst_high", 4'b1000, 32'h00000010, 32'h00000003, 32'h0000000D, 1'b0, 1'b0);
    checkOutput();
    reset = 1'b0;
    applyStimulus("rst_after", 4'b1000, 32'h00000010, 32'h00000003, 32'h0000000D, 1'b0, 1'b0);
    checkOutput();

    // Random regression against the reference model. Every eighth vector
    // forces a == b so the equal flag is exercised in both states.
    for (int n = 0; n < 10000; n++) begin
      logic [3:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rres;
      rop  = 4'($urandom_range(15));
      ra   = $urandom;
      rb   = ((n % 8) == 0) ? ra : $urandom;
      rres = modelResult(rop, ra, rb);
      applyStimulus("random", rop, ra, rb, rres, (rres == 32'h0), (ra == rb));
      checkOutput();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
